revision_fetch: RTL and testbench
=================================

Name: revision_fetch

Overview:
- AXI4-Lite read-only master that sequences the build-revision register block.
- Reads all seven revision registers in order (major, minor, build, release candidate, date, RTL type, RTL subtype) and latches them into parallel outputs.
- Runs automatically after reset or on a start pulse, so local logic (LED/status, PCIe BAR mirror, self-check) sees revision data without a CPU.
- Flags error responses and stalled transactions.

Parameters:
- M_AXI_ADDR_WIDTH, 5: width of ARADDR.
- M_AXI_DATA_WIDTH, 32: width of RDATA and of each latched output.
- BASE_ADDR, 0: byte address of register 0 in the revision block.
- TIMEOUT_CYCLES, 1024: cycles one transaction may take before `timeout` sets; legal range 2..65535.
- AUTO_START, 1: if 1, a scan starts automatically in the first cycle after reset deasserts.

Ports:
- AXI_ACLK  in  1  sole clock
- AXI_ARESET  in  1  reset; synchronous, active-high
- start  in  1  single-cycle scan request
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan completion
- valid  out  1  high once a scan completes; cleared at the next scan start
- err_mask  out  7  bit i set if register i returned RRESP != OKAY
- timeout  out  1  sticky: some transaction in this scan exceeded TIMEOUT_CYCLES
- rev_major, rev_minor, rev_build, rev_rcand, rev_date, rtl_type, rtl_subtype  out  32 each  latched register values
- M_AXI_ARADDR  out  M_AXI_ADDR_WIDTH  read address
- M_AXI_ARVALID  out  1
- M_AXI_ARPROT  out  3  constant 0
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  M_AXI_DATA_WIDTH
- M_AXI_RVALID  in  1
- M_AXI_RRESP  in  2
- M_AXI_RREADY  out  1

Behaviour:
- Reset values: all outputs 0 (ARVALID, RREADY, busy, done, valid, err_mask, timeout, all data outputs, ARADDR); FSM in IDLE; index 0.
- Reset mid-scan: all outputs return to reset values on the next edge. ARVALID may drop without handshake; the slave shares this reset.
- FSM states:
  - IDLE: busy=0. Leave on start, or on the first post-reset cycle when AUTO_START=1.
  - ISSUE:
    - ARVALID=1, ARADDR=BASE_ADDR+4*index (truncated to M_AXI_ADDR_WIDTH).
    - ARVALID and ARADDR are held stable until the cycle where ARVALID&ARREADY.
    - Then ARVALID=0 and go to WAIT_R.
  - WAIT_R:
    - RREADY=1.
    - On RVALID&RREADY: latch RDATA into output[index] and set err_mask[index] if RRESP != 0. Data is latched even on error.
    - Then RREADY=0. If index==6, go to DONE; otherwise index+1 and go to ISSUE.
  - DONE:
    - done=1 for exactly this cycle; valid=1 from this edge; busy=0.
    - If start is high in this cycle, go to ISSUE; otherwise go to IDLE.
- Scan start (IDLE/DONE to ISSUE):
  - index=0, busy=1, valid=0, err_mask=0, timeout=0.
  - Data outputs retain previous values until overwritten.
- start:
  - Sampled only in IDLE and DONE; ignored in ISSUE/WAIT_R (no queueing).
  - In IDLE, ARVALID asserts the cycle after start.
- Only one outstanding transaction. ARVALID and RREADY are never high in the same cycle.
- Timeout:
  - A per-transaction counter clears on entry to ISSUE and counts each ISSUE/WAIT_R cycle.
  - When the count reaches TIMEOUT_CYCLES, `timeout` sets and holds; the counter saturates.
  - The transaction is NOT abandoned (AXI forbids withdrawing ARVALID), and the scan continues normally if the slave later responds.
- Latency: with a slave that gives ARREADY=1 and RVALID 2 cycles after the AR handshake, a scan takes at most 7*4+2 cycles from start to done.

Test Plan:
- AUTO_START=1, responsive slave returning 0x1,0x2,0x3,0x0,0x07040018,0xA,0xB:
  - One scan with ARADDR 0x00,0x04,...,0x18.
  - Outputs latch those values; done pulses once; valid=1; err_mask=0; timeout=0.
- Slave returns RRESP=SLVERR(2) for address 0x0C only:
  - err_mask=7'b0001000; rev_rcand still latches the returned RDATA; done and valid still assert.
- Slave holds ARREADY=0 for 1500 cycles on address 0x08:
  - timeout=1 at cycle 1024 of that transaction; ARVALID and ARADDR stay stable throughout; scan completes afterwards.
- start pulsed while busy, then again in the DONE cycle:
  - The first pulse is ignored.
  - The second begins a new scan next cycle with ARADDR=0x00; valid drops to 0 until that scan's done.
- AXI_ARESET asserted during WAIT_R of register 4:
  - Next edge: ARVALID=0, RREADY=0, busy=0, valid=0, data outputs=0.
  - After release with AUTO_START=1, a full fresh scan runs.
- Slave delays RVALID randomly 0–20 cycles and toggles ARREADY randomly:
  - Values match the slave model; ARVALID and RREADY are never high together.

Source files
------------

// File: rtl/revision_fetch.sv
// AXI4-Lite read-only master that walks the seven build-revision registers
// and latches them onto parallel outputs, with per-register error flags and a stall timeout.
module revision_fetch #(
    parameter int M_AXI_ADDR_WIDTH = 5,
    parameter int M_AXI_DATA_WIDTH = 32,
    parameter int BASE_ADDR        = 0,
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int AUTO_START       = 1
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_ARESET,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        valid,
    output logic [6:0]                  err_mask,
    output logic                        timeout,
    output logic [M_AXI_DATA_WIDTH-1:0] rev_major,
    output logic [M_AXI_DATA_WIDTH-1:0] rev_minor,
    output logic [M_AXI_DATA_WIDTH-1:0] rev_build,
    output logic [M_AXI_DATA_WIDTH-1:0] rev_rcand,
    output logic [M_AXI_DATA_WIDTH-1:0] rev_date,
    output logic [M_AXI_DATA_WIDTH-1:0] rtl_type,
    output logic [M_AXI_DATA_WIDTH-1:0] rtl_subtype,
    output logic [M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                        M_AXI_ARVALID,
    output logic [2:0]                  M_AXI_ARPROT,
    input  logic                        M_AXI_ARREADY,
    input  logic [M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic                        M_AXI_RVALID,
    input  logic [1:0]                  M_AXI_RRESP,
    output logic                        M_AXI_RREADY
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT_R = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int NUM_REGS = 7;
    localparam int CNT_W    = 16;
    localparam logic [CNT_W-1:0] TMO_LIMIT    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic                        srst;
    logic [1:0]                  state_reg, state_next;
    logic [2:0]                  index_reg, index_next;
    logic [M_AXI_ADDR_WIDTH-1:0] araddr_reg, araddr_next;
    logic                        auto_pending_reg;
    logic [CNT_W-1:0]            tmo_cnt_reg;
    logic                        timeout_reg;
    logic                        valid_reg;
    logic                        scan_start;
    logic                        ar_hs;
    logic                        r_hs;
    logic                        last_reg;
    logic                        in_txn;
    logic                        issue_entry;
    logic [M_AXI_DATA_WIDTH-1:0] value_bus [NUM_REGS];

    assign srst = AXI_ARESET;

    function automatic logic [M_AXI_ADDR_WIDTH-1:0] reg_addr(input logic [2:0] idx);
        return M_AXI_ADDR_WIDTH'(BASE_ADDR + 4 * int'(idx));
    endfunction

    // A scan may begin from IDLE (start or the one-shot post-reset kick) or
    // straight out of DONE when start is already waiting there.
    assign scan_start = ((state_reg == ST_IDLE) && (start || auto_pending_reg)) ||
                        ((state_reg == ST_DONE) && start);
    assign ar_hs       = (state_reg == ST_ISSUE) && M_AXI_ARREADY;
    assign r_hs        = (state_reg == ST_WAIT_R) && M_AXI_RVALID;
    assign last_reg    = (index_reg == 3'(NUM_REGS - 1));
    assign in_txn      = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT_R);
    assign issue_entry = (state_next == ST_ISSUE) && (state_reg != ST_ISSUE);

    always_comb begin
        state_next  = state_reg;
        index_next  = index_reg;
        araddr_next = araddr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (scan_start) begin
                    state_next  = ST_ISSUE;
                    index_next  = 3'd0;
                    araddr_next = reg_addr(3'd0);
                end
            end
            ST_ISSUE: begin
                if (ar_hs) begin
                    state_next = ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (r_hs) begin
                    if (last_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next  = ST_ISSUE;
                        index_next  = index_reg + 3'd1;
                        araddr_next = reg_addr(index_reg + 3'd1);
                    end
                end
            end
            ST_DONE: begin
                if (scan_start) begin
                    state_next  = ST_ISSUE;
                    index_next  = 3'd0;
                    araddr_next = reg_addr(3'd0);
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (srst) begin
            state_reg        <= ST_IDLE;
            index_reg        <= 3'd0;
            araddr_reg       <= '0;
            auto_pending_reg <= (AUTO_START != 0);
        end else begin
            state_reg        <= state_next;
            index_reg        <= index_next;
            araddr_reg       <= araddr_next;
            auto_pending_reg <= 1'b0;
        end
    end

    // Stall watchdog: the transaction keeps running after it fires, since an
    // issued ARVALID cannot be withdrawn.
    always_ff @(posedge AXI_ACLK) begin
        if (srst) begin
            tmo_cnt_reg <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (issue_entry) begin
                tmo_cnt_reg <= '0;
            end else if (in_txn && (tmo_cnt_reg != TMO_LIMIT)) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end

            if (scan_start) begin
                timeout_reg <= 1'b0;
            end else if (in_txn && (tmo_cnt_reg == TMO_LAST_CNT)) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (srst) begin
            valid_reg <= 1'b0;
        end else if (scan_start) begin
            valid_reg <= 1'b0;
        end else if (r_hs && last_reg) begin
            valid_reg <= 1'b1;
        end
    end

    // One capture slot per register; data is kept even when the slave flags an error.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slot
            logic [M_AXI_DATA_WIDTH-1:0] value_reg;
            logic                        err_reg;

            always_ff @(posedge AXI_ACLK) begin
                if (srst) begin
                    value_reg <= '0;
                    err_reg   <= 1'b0;
                end else if (r_hs && (index_reg == 3'(gi))) begin
                    value_reg <= M_AXI_RDATA;
                    err_reg   <= (M_AXI_RRESP != 2'b00);
                end else if (scan_start) begin
                    err_reg   <= 1'b0;
                end
            end

            assign value_bus[gi] = value_reg;
            assign err_mask[gi]  = err_reg;
        end
    endgenerate

    assign rev_major   = value_bus[0];
    assign rev_minor   = value_bus[1];
    assign rev_build   = value_bus[2];
    assign rev_rcand   = value_bus[3];
    assign rev_date    = value_bus[4];
    assign rtl_type    = value_bus[5];
    assign rtl_subtype = value_bus[6];

    assign busy          = in_txn;
    assign done          = (state_reg == ST_DONE);
    assign valid         = valid_reg;
    assign timeout       = timeout_reg;
    assign M_AXI_ARVALID = (state_reg == ST_ISSUE);
    assign M_AXI_RREADY  = (state_reg == ST_WAIT_R);
    assign M_AXI_ARADDR  = araddr_reg;
    assign M_AXI_ARPROT  = 3'b000;

endmodule

// File: tb/tb_revision_fetch.sv
// Bench for revision_fetch: a reactive AXI4-Lite slave model plus scan-level
// expectations (register contents, address order, error mask, timeout, handshake rules).
module tb_revision_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy, done, valid, timeout;
    logic [6:0]  err_mask;
    logic [31:0] rev_major, rev_minor, rev_build, rev_rcand, rev_date, rtl_type, rtl_subtype;
    logic [4:0]  araddr;
    logic        arvalid, rready;
    logic [2:0]  arprot;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic        s_rvalid;
    logic [1:0]  s_rresp;

    revision_fetch dut (
        .AXI_ACLK      (clk),
        .AXI_ARESET    (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .valid         (valid),
        .err_mask      (err_mask),
        .timeout       (timeout),
        .rev_major     (rev_major),
        .rev_minor     (rev_minor),
        .rev_build     (rev_build),
        .rev_rcand     (rev_rcand),
        .rev_date      (rev_date),
        .rtl_type      (rtl_type),
        .rtl_subtype   (rtl_subtype),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARREADY (s_arready),
        .M_AXI_RDATA   (s_rdata),
        .M_AXI_RVALID  (s_rvalid),
        .M_AXI_RRESP   (s_rresp),
        .M_AXI_RREADY  (rready)
    );

    logic [31:0] dut_data [7];
    assign dut_data[0] = rev_major;
    assign dut_data[1] = rev_minor;
    assign dut_data[2] = rev_build;
    assign dut_data[3] = rev_rcand;
    assign dut_data[4] = rev_date;
    assign dut_data[5] = rtl_type;
    assign dut_data[6] = rtl_subtype;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset as seen by the DUT at the most recent rising edge.
    logic rst_q;
    always @(posedge clk) rst_q <= rst;

    int tests  = 0;
    int failed = 0;

    // Slave configuration and register contents.
    logic [31:0] mem [7];
    logic [6:0]  err_sel;
    int          fixed_delay;
    bit          rnd_mode;
    logic [4:0]  stall_addr;
    int          stall_left;

    // Monitor results.
    logic [4:0]  ar_log [$];
    int          done_cnt;
    int          overlap_viol;
    int          stab_viol;
    int          valid_viol;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave + protocol monitor; inputs change on falling edges only.
    initial begin
        bit          pending;
        logic [4:0]  paddr;
        int          delay;
        logic        prev_arvalid, prev_arready, prev_rvalid, prev_rready;
        logic [4:0]  prev_araddr;
        pending = 0; paddr = '0; delay = 0;
        prev_arvalid = 0; prev_arready = 0; prev_rvalid = 0; prev_rready = 0; prev_araddr = '0;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = 2'b00;
        done_cnt = 0; overlap_viol = 0; stab_viol = 0; valid_viol = 0;
        forever begin
            @(negedge clk);
            if (arvalid && rready) overlap_viol++;
            if (busy && valid) valid_viol++;
            if (done) done_cnt++;
            if (rst_q) begin
                pending   = 0;
                s_rvalid  = 0;
                s_arready = 0;
            end else begin
                if (prev_arvalid && !prev_arready && (!arvalid || araddr !== prev_araddr))
                    stab_viol++;
                if (prev_rvalid && prev_rready) begin
                    pending  = 0;
                    s_rvalid = 0;
                end
                if (prev_arvalid && prev_arready) begin
                    pending = 1;
                    paddr   = prev_araddr;
                    delay   = rnd_mode ? int'($urandom_range(0, 20)) : fixed_delay;
                    ar_log.push_back(prev_araddr);
                end
                if (pending && !s_rvalid) begin
                    if (delay == 0) begin
                        s_rvalid = 1;
                        s_rdata  = mem[paddr[4:2]];
                        s_rresp  = err_sel[paddr[4:2]] ? 2'b10 : 2'b00;
                    end else begin
                        delay--;
                    end
                end
                if (arvalid && araddr == stall_addr && stall_left > 0) begin
                    s_arready = 0;
                    stall_left--;
                end else if (rnd_mode) begin
                    s_arready = 1'($urandom_range(0, 1));
                end else begin
                    s_arready = 1;
                end
            end
            prev_arvalid = arvalid;
            prev_arready = s_arready;
            prev_araddr  = araddr;
            prev_rvalid  = s_rvalid;
            prev_rready  = rready;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        bit ok;
        ok = 0;
        cycles = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_arvalid"}, 32'(arvalid), 32'd0);
        check({tag, "_rready"}, 32'(rready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_err"}, 32'(err_mask), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_araddr"}, 32'(araddr), 32'd0);
        check({tag, "_arprot"}, 32'(arprot), 32'd0);
        for (int i = 0; i < 7; i++)
            check($sformatf("%s_data%0d", tag, i), dut_data[i], 32'd0);
    endtask

    // Called in the done cycle: contents, flags and the address sequence of the scan.
    task automatic check_scan(input string tag, input logic [6:0] exp_err, input logic exp_tmo);
        for (int i = 0; i < 7; i++)
            check($sformatf("%s_data%0d", tag, i), dut_data[i], mem[i]);
        check({tag, "_err"}, 32'(err_mask), 32'(exp_err));
        check({tag, "_timeout"}, 32'(timeout), 32'(exp_tmo));
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ar_count"}, 32'(ar_log.size()), 32'd7);
        for (int i = 0; i < ar_log.size() && i < 7; i++)
            check($sformatf("%s_araddr%0d", tag, i), 32'(ar_log[i]), 32'(i * 4));
        $display("[TB] scan %s: err_mask=%b timeout=%0d data0=0x%0h", tag, err_mask, timeout, rev_major);
    endtask

    typedef struct {
        string      name;
        logic [6:0] err_sel;
        int         delay;
        bit         rnd;
        logic [6:0] exp_err;
        bit         check_lat;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int   cyc;
        int   done_base;
        int   k;
        bit   seen;

        vecs[0] = '{"slverr_0c",   7'b0001000, 2, 1'b0, 7'b0001000, 1'b1};
        vecs[1] = '{"clean_lat",   7'b0000000, 2, 1'b0, 7'b0000000, 1'b1};
        vecs[2] = '{"err_ends",    7'b1000001, 0, 1'b0, 7'b1000001, 1'b0};
        vecs[3] = '{"rand_a",      7'b0000000, 0, 1'b1, 7'b0000000, 1'b0};
        vecs[4] = '{"rand_err",    7'b0100110, 0, 1'b1, 7'b0100110, 1'b0};
        vecs[5] = '{"rand_b",      7'b0000000, 0, 1'b1, 7'b0000000, 1'b0};

        rst = 1'b1; start = 1'b0;
        err_sel = '0; fixed_delay = 2; rnd_mode = 0; stall_addr = 5'h1f; stall_left = 0;
        mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h3; mem[3] = 32'h0;
        mem[4] = 32'h07040018; mem[5] = 32'hA; mem[6] = 32'hB;
        repeat (3) @(negedge clk);
        check_reset("reset");

        // Automatic scan after reset release, no start pulse.
        ar_log.delete();
        done_base = done_cnt;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 3 && !seen; i++) begin
            @(negedge clk);
            if (arvalid) seen = 1;
        end
        check("auto_start_arvalid", 32'(seen), 32'd1);
        wait_done("auto", 200, cyc);
        check_scan("auto", 7'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("auto_done_pulses", 32'(done_cnt - done_base), 32'd1);
        check("auto_idle_busy", 32'(busy), 32'd0);
        check("auto_valid_held", 32'(valid), 32'd1);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 7; i++) mem[i] = $urandom;
            err_sel = vecs[v].err_sel;
            fixed_delay = vecs[v].delay;
            rnd_mode = vecs[v].rnd;
            ar_log.delete();
            pulse_start();
            wait_done(vecs[v].name, 2000, cyc);
            if (vecs[v].check_lat)
                check({vecs[v].name, "_latency_ok"}, 32'(cyc <= 7 * 4 + 2), 32'd1);
            check_scan(vecs[v].name, vecs[v].exp_err, 1'b0);
            repeat (3) @(negedge clk);
        end

        // ARREADY held low for 1500 cycles on address 0x08.
        rnd_mode = 0; err_sel = '0; fixed_delay = 1;
        for (int i = 0; i < 7; i++) mem[i] = $urandom;
        stall_addr = 5'h08; stall_left = 1500;
        ar_log.delete();
        pulse_start();
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (arvalid && araddr == 5'h08) seen = 1;
            else @(negedge clk);
        end
        check("tmo_reach_0x08", 32'(seen), 32'd1);
        k = 1;
        while (k < 1026) begin
            @(negedge clk);
            k++;
            if (k == 1023) check("tmo_before_limit", 32'(timeout), 32'd0);
        end
        check("tmo_after_limit", 32'(timeout), 32'd1);
        check("tmo_arvalid_held", 32'(arvalid), 32'd1);
        check("tmo_araddr_held", 32'(araddr), 32'h08);
        wait_done("tmo", 3000, cyc);
        check_scan("tmo", 7'b0, 1'b1);
        stall_left = 0; stall_addr = 5'h1f;
        repeat (3) @(negedge clk);

        // start while busy is dropped; start in the done cycle restarts at once.
        for (int i = 0; i < 7; i++) mem[i] = $urandom;
        fixed_delay = 2;
        ar_log.delete();
        pulse_start();
        repeat (5) @(negedge clk);
        check("restart_busy_mid", 32'(busy), 32'd1);
        pulse_start();
        wait_done("restart_a", 200, cyc);
        check_scan("restart_a", 7'b0, 1'b0);
        done_base = done_cnt;
        start = 1'b1;
        ar_log.delete();
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_arvalid", 32'(arvalid), 32'd1);
        check("restart_araddr", 32'(araddr), 32'h00);
        check("restart_valid_clr", 32'(valid), 32'd0);
        repeat (4) @(negedge clk);
        pulse_start();
        wait_done("restart_b", 200, cyc);
        check_scan("restart_b", 7'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("restart_no_queue", 32'(busy), 32'd0);
        check("restart_done_pulses", 32'(done_cnt - done_base), 32'd1);

        // Reset during the data phase of register 4.
        for (int i = 0; i < 7; i++) mem[i] = $urandom;
        fixed_delay = 4;
        pulse_start();
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (rready && araddr == 5'h10) seen = 1;
            else @(negedge clk);
        end
        check("midrst_reach_reg4", 32'(seen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        ar_log.delete();
        for (int i = 0; i < 7; i++) mem[i] = $urandom;
        fixed_delay = 1;
        rst = 1'b0;
        wait_done("postrst", 200, cyc);
        check_scan("postrst", 7'b0, 1'b0);

        check("no_arvalid_rready_overlap", 32'(overlap_viol), 32'd0);
        check("ar_stable_until_hs", 32'(stab_viol), 32'd0);
        check("valid_low_while_busy", 32'(valid_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
